// File: rtl/imem_loader.sv
// Instruction-memory program loader: packs a little-endian byte stream into
// 32-bit words, writes them upward from address 0 and holds the core in reset meanwhile.
module imem_loader #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 32,
   parameter int unsigned LW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic [LW-1:0] load_len,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          core_rst_n,
   output logic          busy,
   output logic          done,
   output logic          error
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   word_q, word_d;
   logic          in_ready_q, in_ready_d;
   logic          we_q, we_d;
   logic          crn_q, crn_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic          xfer;
   logic          len_zero;
   logic          len_too_big;
   logic [LW-1:0] cnt_inc;

   // in_ready_q is high exactly while in RECV, so it doubles as the state qualifier
   assign xfer        = in_valid && in_ready_q;
   assign len_zero    = (load_len == '0);
   assign len_too_big = (64'(load_len) > 64'(DEPTH));
   assign cnt_inc     = cnt_q + LW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               if (len_zero) begin
                  state_d = ST_DONE;
               end else if (!len_too_big) begin
                  state_d = ST_RECV;
               end
            end
         end
         ST_RECV: begin
            if (xfer && (idx_q == 2'd3)) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_d = (cnt_inc == len_q) ? ST_DONE : ST_RECV;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so each one
   // is valid in the same cycle the FSM occupies the corresponding state.
   always_comb begin
      len_d   = len_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      word_d  = word_q;
      error_d = error_q;

      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               if (len_too_big) begin
                  error_d = 1'b1;
               end else if (!len_zero) begin
                  len_d  = load_len;
                  cnt_d  = '0;
                  idx_d  = '0;
                  addr_d = '0;
                  word_d = '0;
               end
            end
         end
         ST_RECV: begin
            if (xfer) begin
               word_d[{idx_q, 3'b000} +: 8] = in_data;
               idx_d                        = idx_q + 2'd1;
            end
         end
         ST_WRITE: begin
            addr_d = addr_q + AW'(4);
            cnt_d  = cnt_inc;
         end
         default: begin
         end
      endcase

      in_ready_d = (state_d == ST_RECV);
      we_d       = (state_d == ST_WRITE);
      busy_d     = (state_d == ST_RECV) || (state_d == ST_WRITE);
      done_d     = (state_d == ST_DONE);
      crn_d      = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q      <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         word_q     <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         crn_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         crn_q      <= crn_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = word_q;
   assign core_rst_n = crn_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

   a_we_no_ready : assert property (@(posedge clk) disable iff (!rst) imem_we |-> !in_ready);
   a_we_single   : assert property (@(posedge clk) disable iff (!rst) imem_we |=> !imem_we);
   a_addr_align  : assert property (@(posedge clk) disable iff (!rst) imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a byte/word-level model predicts
// the write sequence, done timing and core reset window of every load.
module tb_imem_loader;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 32;
   localparam int unsigned LW    = 16;

   logic          clk;
   logic          rst;
   logic          load_start;
   logic [LW-1:0] load_len;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst_n;
   logic          busy;
   logic          done;
   logic          error;

   imem_loader #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_len   (load_len),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   logic [63:0] wr_q[$];
   int          done_q[$];
   bit          crn_hist[int];
   bit          busy_hist[int];
   logic [7:0]  stim_b[$];
   int          stim_g[$];
   bit          exp_err = 1'b0;

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(negedge clk);
         crn_hist[cyc]  = core_rst_n;
         busy_hist[cyc] = busy;
         if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
         if (done) done_q.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Random bytes; stalls only inside a word so they land while the loader is receiving.
   task automatic make_stim(input int n, input int gapmax);
      stim_b.delete();
      stim_g.delete();
      for (int k = 0; k < 4 * n; k++) begin
         stim_b.push_back(8'($urandom));
         stim_g.push_back(((k % 4) != 0 && gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      end
   endtask

   task automatic drive_bytes(input bit poke, output bit ok);
      bit rdy;
      int budget;
      ok = 1'b1;
      for (int k = 0; k < stim_b.size(); k++) begin
         if (stim_g[k] > 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            for (int g = 0; g < stim_g[k]; g++) begin
               if (poke && g == 0) begin
                  load_start = 1'b1;
                  load_len   = LW'(1);
               end
               @(posedge clk);
               #1;
               load_start = 1'b0;
            end
         end
         in_valid = 1'b1;
         in_data  = stim_b[k];
         budget   = 0;
         do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            budget++;
         end while (!rdy && budget < 20);
         if (!rdy) begin
            check("xfer_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            ok = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // Called just after a rising edge; checks writes, done time and reset window.
   task automatic run_load(input string tag, input int n, input bit poke);
      int c, exp_done, gsum, ones, nchk;
      bit ok;
      logic [31:0] w;
      wr_q.delete();
      done_q.delete();
      gsum = 0;
      foreach (stim_g[k]) gsum += stim_g[k];
      c          = cyc;
      load_start = 1'b1;
      load_len   = LW'(n);
      @(posedge clk);
      #1;
      load_start = 1'b0;
      load_len   = LW'($urandom);
      drive_bytes(poke, ok);
      exp_done = c + 1 + 5 * n + gsum;
      while (cyc < exp_done + 2) begin
         @(posedge clk);
         #1;
      end
      check({tag, "_nwr"}, 64'(wr_q.size()), 64'(n));
      nchk = (wr_q.size() < n) ? wr_q.size() : n;
      for (int i = 0; i < nchk; i++) begin
         w = {stim_b[4*i+3], stim_b[4*i+2], stim_b[4*i+1], stim_b[4*i]};
         check($sformatf("%s_wr%0d", tag, i), wr_q[i], {32'(4 * i), w});
      end
      check({tag, "_ndone"}, 64'(done_q.size()), 64'd1);
      if (done_q.size() > 0) check({tag, "_done_cyc"}, 64'(done_q[0] - c), 64'(exp_done - c));
      ones = 0;
      for (int t = c + 1; t <= exp_done; t++) if (crn_hist.exists(t) && crn_hist[t]) ones++;
      check({tag, "_crn_low"}, 64'(ones), 64'd0);
      check({tag, "_crn_rel"}, 64'(crn_hist[exp_done + 1]), 64'd1);
      check({tag, "_busy_done"}, 64'(busy_hist[exp_done]), 64'd0);
      check({tag, "_busy_start"}, 64'(busy_hist[c + 1]), (n > 0) ? 64'd1 : 64'd0);
      check({tag, "_error"}, 64'(error), 64'(exp_err));
   endtask

   initial begin
      int n;
      bit ok;
      rst        = 1'b0;
      load_start = 1'b0;
      load_len   = '0;
      in_valid   = 1'b0;
      in_data    = '0;

      #12;
      check("rst_ctl", 64'({in_ready, imem_we, core_rst_n, busy, done, error}), 64'd0);
      check("rst_addr", 64'(imem_addr), 64'd0);
      check("rst_wdata", 64'(imem_wdata), 64'd0);
      #3;
      rst = 1'b1;
      #2;
      check("crn_before_edge", 64'(core_rst_n), 64'd0);
      @(posedge clk);
      #1;
      check("crn_release", 64'(core_rst_n), 64'd1);
      check("rst_no_we", 64'(wr_q.size()), 64'd0);

      stim_b = '{8'h13, 8'h00, 8'hA0, 8'h00, 8'h93, 8'h01, 8'h10, 8'h00};
      stim_g = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_load("two_word", 2, 1'b0);
      check("two_word_w0", (wr_q.size() > 0) ? wr_q[0] : 64'd0, 64'h00000000_00A00013);
      check("two_word_w1", (wr_q.size() > 1) ? wr_q[1] : 64'd0, 64'h00000004_00100193);

      stim_g = '{0, 0, 3, 0, 0, 0, 0, 0};
      run_load("backpr", 2, 1'b1);

      stim_b.delete();
      stim_g.delete();
      run_load("zero", 0, 1'b0);

      wr_q.delete();
      done_q.delete();
      load_start = 1'b1;
      load_len   = LW'(DEPTH + 1);
      @(posedge clk);
      #1;
      load_start = 1'b0;
      exp_err    = 1'b1;
      check("ovf_error", 64'(error), 64'd1);
      check("ovf_idle", 64'({busy, in_ready, core_rst_n}), 64'b001);
      repeat (3) @(posedge clk);
      #1;
      check("ovf_no_done", 64'(done_q.size()), 64'd0);
      check("ovf_no_wr", 64'(wr_q.size()), 64'd0);
      check("ovf_crn", 64'(core_rst_n), 64'd1);

      make_stim(DEPTH, 0);
      run_load("full", DEPTH, 1'b0);

      make_stim(4, 0);
      for (int k = 0; k < 10; k++) begin
         void'(stim_b.pop_back());
         void'(stim_g.pop_back());
      end
      wr_q.delete();
      done_q.delete();
      load_start = 1'b1;
      load_len   = LW'(4);
      @(posedge clk);
      #1;
      load_start = 1'b0;
      drive_bytes(1'b0, ok);
      rst = 1'b0;
      #1;
      exp_err = 1'b0;
      check("abort_ctl", 64'({in_ready, imem_we, core_rst_n, busy, done, error}), 64'd0);
      check("abort_addr", 64'(imem_addr), 64'd0);
      check("abort_wdata", 64'(imem_wdata), 64'd0);
      #5;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_q.size()), 64'd0);
      check("abort_nwr", 64'(wr_q.size()), 64'd1);
      check("abort_wr0", (wr_q.size() > 0) ? wr_q[0] : 64'd0,
            {32'd0, stim_b[3], stim_b[2], stim_b[1], stim_b[0]});

      make_stim(1, 0);
      run_load("restart", 1, 1'b0);

      for (int it = 0; it < 10; it++) begin
         n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
         make_stim(n, 3);
         run_load($sformatf("rand%0d", it), n, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writes a program into the pipeline's instruction memory; instruction fetch is the reader of that memory.
- Accepts a little-endian byte stream on a valid/ready handshake and packs each four bytes into a 32-bit word.
- Writes consecutive words from byte address 0.
- Holds the core in reset for the whole load, then releases it, so programs load without hierarchical pokes or $readmemh.

Parameters:
- DEPTH, 256, instruction memory size in 32-bit words.
- AW, 32, width of the byte address presented to instruction memory.
- LW, 16, width of load_len.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- load_len  input  LW  number of 32-bit words to load; sampled with load_start.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte; least-significant byte of each word first.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  AW  word-aligned byte address, bits [1:0] always 0.
- imem_wdata  output  32  assembled instruction word.
- core_rst_n  output  1  active-low reset to top_pipeline.
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse when a load completes.
- error  output  1  sticky; set when a request has load_len > DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, state is IDLE, word counter, byte index and address are 0, and error is cleared. core_rst_n=0 while rst=0. It is driven 1 on the first clock edge after rst rises, because IDLE drives core_rst_n=1.
- All outputs are registered.
- A byte transfer occurs on a rising edge where in_valid=1 and in_ready=1.
- States:
  - IDLE:
    - busy=0, in_ready=0, core_rst_n=1.
    - On load_start with load_len=0: go to DONE. No writes.
    - On load_start with 0 < load_len <= DEPTH: capture load_len, clear address, word counter and byte index, go to RECV.
    - On load_start with load_len > DEPTH: set error, stay in IDLE. core_rst_n is not dropped and done does not pulse.
  - RECV:
    - busy=1, core_rst_n=0, in_ready=1.
    - Each transfer places in_data at bits [8*idx+7 : 8*idx] of the word and increments idx modulo 4.
    - On the transfer with idx=3, go to WRITE.
  - WRITE (exactly one cycle):
    - imem_we=1, with imem_addr and imem_wdata holding the packed word. in_ready=0.
    - Next cycle: imem_addr += 4 and the word counter increments.
    - If the word counter now equals load_len, go to DONE; otherwise return to RECV.
  - DONE (one cycle):
    - done=1, busy=0, core_rst_n stays 0.
    - Next state is IDLE, where core_rst_n=1. The core therefore leaves reset on the edge after the done pulse.
- Timing:
  - Minimum per-word cost is 5 cycles: 4 transfers plus 1 write.
  - From load_start to done is at least 1 + 5*N cycles for N words.
- Stalls: in_valid=0 in RECV leaves all state unchanged, with no timeout.
- Write behaviour:
  - imem_we is never asserted outside WRITE.
  - Writes occur in strictly ascending address order, never reach byte address DEPTH*4 or above, and are never duplicated.
- load_start outside IDLE is ignored. No restart, and load_len is not re-sampled.
- error is cleared only by rst. A later valid request still loads normally while error stays 1.
- rst asserted mid-load aborts immediately. Words already written remain in memory; no completion is signalled.
- Address wrap cannot occur, because load_len <= DEPTH is enforced at request time.

Test Plan:
- Reset release: rst=0 for 15 ns, then 1 -> all outputs 0 during reset; core_rst_n=1 one cycle after release; imem_we never pulses.
- Two-word load, in_valid held 1:
  - Stimulus: load_len=2, bytes 13,00,A0,00,93,01,10,00.
  - Required: write 0x00A00013 at addr 0x0; write 0x00100193 at addr 0x4; done 11 cycles after load_start.
  - core_rst_n: 0 from the RECV cycle until the cycle after done, then 1.
- Back-pressure: same stream with in_valid dropped for 3 cycles mid-word -> identical words and addresses; done arrives 3 cycles later; no extra writes.
- Zero length: load_len=0 -> done pulses 1 cycle later; no imem_we; busy stays 0.
- Overflow request: load_len=DEPTH+1=257 -> error=1 next cycle; state IDLE; core_rst_n stays 1.
- Reset abort and ignored restart:
  - rst pulsed low after 6 bytes of a 4-word load -> outputs clear at once; done never pulses.
  - Restarted load of 1 word writes addr 0x0.
  - load_start asserted during RECV has no effect.
